// File: rtl/rr_stream_arbiter.sv
// Purpose: round-robin, packet-locked arbiter merging NUM_REQ valid/ready beat streams into one egress stream.
// Latency: one IDLE arbitration cycle per packet, then 1 cycle from beat acceptance to e_valid_o.
// Backpressure: egress stalls fill a 2-entry main/skid buffer; i_ready_o of the grantee drops while skid holds a beat.
//
// Ports:
//   clk, reset_n            - single rising-edge clock, asynchronous active-low reset
//   i_valid_i/i_data_i/i_last_i/i_ready_o
//                           - per-requester beat stream; requester k's data is i_data_i[k*DATA_W +: DATA_W]
//   e_valid_o/e_data_o/e_last_o/e_ready_i
//                           - merged egress stream, driven straight from the main register
//   grant_o                 - one-hot grant, zero while arbitrating or idle
//   busy_o                  - high while a packet is locked
module rr_stream_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        i_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] i_data_i,
    input  logic [NUM_REQ-1:0]        i_last_i,
    output logic [NUM_REQ-1:0]        i_ready_o,
    output logic                      e_valid_o,
    output logic [DATA_W-1:0]         e_data_o,
    output logic                      e_last_o,
    input  logic                      e_ready_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;

    logic                 arb_found;
    logic [NUM_REQ-1:0]   arb_onehot;
    logic                 beat_vld;
    logic                 beat_last;
    logic [DATA_W-1:0]    beat_dat;
    logic [PTR_W-1:0]     ptr_after;
    logic                 accept;
    logic                 pop;

    logic                 main_vld, skid_vld;
    logic                 main_last, skid_last;
    logic [DATA_W-1:0]    main_dat, skid_dat;

    // First valid requester scanning ptr, ptr+1, ... modulo NUM_REQ.
    always_comb begin
        arb_found  = 1'b0;
        arb_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!arb_found && (k == (int'(ptr_q) + i) % NUM_REQ) && i_valid_i[k]) begin
                    arb_found     = 1'b1;
                    arb_onehot[k] = 1'b1;
                end
            end
        end
    end

    // Select the granted requester's beat and the pointer value that follows it.
    always_comb begin
        beat_vld  = 1'b0;
        beat_last = 1'b0;
        beat_dat  = '0;
        ptr_after = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) begin
                beat_vld  = i_valid_i[k];
                beat_last = i_last_i[k];
                beat_dat  = i_data_i[k*DATA_W +: DATA_W];
                ptr_after = (k == NUM_REQ - 1) ? '0 : PTR_W'(k + 1);
            end
        end
    end

    // Ready only when the skid slot is free, so a stalled egress never loses a beat.
    assign i_ready_o = (state_q == LOCKED && !skid_vld) ? grant_q : '0;
    assign accept    = (state_q == LOCKED) && beat_vld && !skid_vld;
    assign pop       = main_vld && e_ready_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = LOCKED;
                    grant_d = arb_onehot;
                end
            end
            LOCKED: begin
                // Grant is held until the last beat; a valid gap never releases it.
                if (accept && beat_last) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_after;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // Main/skid egress buffer. Skid only fills when main is occupied and not draining.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_vld  <= 1'b0;
            main_last <= 1'b0;
            main_dat  <= '0;
            skid_vld  <= 1'b0;
            skid_last <= 1'b0;
            skid_dat  <= '0;
        end else if (pop) begin
            if (skid_vld) begin
                main_dat  <= skid_dat;
                main_last <= skid_last;
                skid_vld  <= 1'b0;
            end else if (accept) begin
                main_dat  <= beat_dat;
                main_last <= beat_last;
            end else begin
                main_vld  <= 1'b0;
            end
        end else if (accept) begin
            if (!main_vld) begin
                main_vld  <= 1'b1;
                main_dat  <= beat_dat;
                main_last <= beat_last;
            end else begin
                skid_vld  <= 1'b1;
                skid_dat  <= beat_dat;
                skid_last <= beat_last;
            end
        end
    end

    assign e_valid_o = main_vld;
    assign e_data_o  = main_dat;
    assign e_last_o  = main_last;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q == LOCKED);

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Purpose: directed self-checking bench for rr_stream_arbiter (NUM_REQ=4, DATA_W=8).
// Latency: requester scripts are applied 1 time unit after each rising edge; DUT outputs are checked on falling edges.
// Backpressure: e_ready_i is driven per scenario; requester scripts only advance on a real handshake.
module tb_rr_stream_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic [NR-1:0]     i_valid_i = '0;
    logic [NR*DW-1:0]  i_data_i  = '0;
    logic [NR-1:0]     i_last_i  = '0;
    logic [NR-1:0]     i_ready_o;
    logic              e_valid_o;
    logic [DW-1:0]     e_data_o;
    logic              e_last_o;
    logic              e_ready_i = 1'b1;
    logic [NR-1:0]     grant_o;
    logic              busy_o;

    rr_stream_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid_i (i_valid_i),
        .i_data_i  (i_data_i),
        .i_last_i  (i_last_i),
        .i_ready_o (i_ready_o),
        .e_valid_o (e_valid_o),
        .e_data_o  (e_data_o),
        .e_last_o  (e_last_o),
        .e_ready_i (e_ready_i),
        .grant_o   (grant_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [8:0]    req_mem [NR][16];
    int            req_len [NR] = '{default: 0};
    int            req_head[NR] = '{default: 0};
    logic [NR-1:0] hold     = '0;
    logic [8:0]    out_q[$];
    int            out_cyc[$];
    logic [NR-1:0] gnt_q[$];
    logic          busy_prev = 1'b0;
    int            cyc = 0;

    // Requester scripts and egress capture: handshakes are taken from pre-edge values.
    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < NR; k++)
                if (i_valid_i[k] && i_ready_o[k]) req_head[k] = req_head[k] + 1;
            if (e_valid_o && e_ready_i) begin
                out_q.push_back({e_last_o, e_data_o});
                out_cyc.push_back(cyc);
            end
            cyc = cyc + 1;
            #1;
            for (int k = 0; k < NR; k++) begin
                if (req_head[k] < req_len[k] && !hold[k]) begin
                    i_valid_i[k]           = 1'b1;
                    i_data_i[k*DW +: DW]   = req_mem[k][req_head[k]][7:0];
                    i_last_i[k]            = req_mem[k][req_head[k]][8];
                end else begin
                    i_valid_i[k] = 1'b0;
                    i_last_i[k]  = 1'b0;
                end
            end
        end
    end

    // Log each grant at the start of a locked packet.
    initial begin
        forever begin
            @(negedge clk);
            if (busy_o && !busy_prev) gnt_q.push_back(grant_o);
            busy_prev = busy_o;
        end
    end

    task automatic push_beat(input int k, input logic [7:0] d, input logic l);
        req_mem[k][req_len[k]] = {l, d};
        req_len[k] = req_len[k] + 1;
    endtask

    task automatic clear_all();
        for (int k = 0; k < NR; k++) begin
            req_len[k]  = 0;
            req_head[k] = 0;
        end
        hold = '0;
        out_q.delete();
        out_cyc.delete();
        gnt_q.delete();
    endtask

    function automatic bit drained();
        drained = 1'b1;
        for (int k = 0; k < NR; k++)
            if (req_head[k] < req_len[k]) drained = 1'b0;
    endfunction

    task automatic wait_done(input int n, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (out_q.size() >= n && drained() && !busy_o && !e_valid_o) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (e_valid_o !== 1'b0) $display("FAIL rst_e_valid: got %b want 0", e_valid_o); else n_pass++;
        n_checks++; if (grant_o !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", grant_o); else n_pass++;
        n_checks++; if (i_ready_o !== 4'b0000) $display("FAIL rst_i_ready: got %b want 0000", i_ready_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else n_pass++;
        n_checks++; if (e_data_o !== 8'h00) $display("FAIL rst_e_data: got %h want 00", e_data_o); else n_pass++;
        n_checks++; if (e_last_o !== 1'b0) $display("FAIL rst_e_last: got %b want 0", e_last_o); else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_idle_busy: got %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [8:0]    exp_o[5];
        logic [NR-1:0] exp_g[5];
        bit            to;
        exp_o = '{9'h100, 9'h101, 9'h102, 9'h103, 9'h100};
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        @(negedge clk);
        clear_all();
        push_beat(0, 8'h00, 1'b1);
        push_beat(0, 8'h00, 1'b1);
        push_beat(1, 8'h01, 1'b1);
        push_beat(2, 8'h02, 1'b1);
        push_beat(3, 8'h03, 1'b1);
        wait_done(5, to);
        n_checks++; if (to !== 1'b0) $display("FAIL rr_timeout: got %b want 0", to); else n_pass++;
        n_checks++; if (out_q.size() != 5) $display("FAIL rr_count: got %0d want 5", out_q.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= out_q.size()) $display("FAIL rr_out[%0d]: missing, want %h", i, exp_o[i]);
            else if (out_q[i] !== exp_o[i]) $display("FAIL rr_out[%0d]: got %h want %h", i, out_q[i], exp_o[i]);
            else n_pass++;
            n_checks++;
            if (i >= gnt_q.size()) $display("FAIL rr_grant[%0d]: missing, want %b", i, exp_g[i]);
            else if (gnt_q[i] !== exp_g[i]) $display("FAIL rr_grant[%0d]: got %b want %b", i, gnt_q[i], exp_g[i]);
            else n_pass++;
        end
        n_checks++;
        if (out_cyc.size() < 2) $display("FAIL rr_spacing: only %0d beats", out_cyc.size());
        else if (out_cyc[1] - out_cyc[0] != 2) $display("FAIL rr_spacing: got %0d want 2", out_cyc[1] - out_cyc[0]);
        else n_pass++;
    endtask

    task automatic test_latency();
        @(negedge clk);
        clear_all();
        push_beat(1, 8'h5A, 1'b1);
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL lat_no_early_grant: got %b want 0", busy_o); else n_pass++;
        @(negedge clk);
        n_checks++; if (grant_o !== 4'b0010) $display("FAIL lat_grant: got %b want 0010", grant_o); else n_pass++;
        n_checks++; if (i_ready_o !== 4'b0010) $display("FAIL lat_ready: got %b want 0010", i_ready_o); else n_pass++;
        n_checks++; if (e_valid_o !== 1'b0) $display("FAIL lat_e_valid_pre: got %b want 0", e_valid_o); else n_pass++;
        @(negedge clk);
        n_checks++; if ({e_valid_o, e_last_o, e_data_o} !== 10'h35A) $display("FAIL lat_egress: got %h want 35a", {e_valid_o, e_last_o, e_data_o}); else n_pass++;
        n_checks++; if ({busy_o, grant_o} !== 5'b00000) $display("FAIL lat_release: got %b want 00000", {busy_o, grant_o}); else n_pass++;
        @(negedge clk);
        n_checks++; if (e_valid_o !== 1'b0) $display("FAIL lat_drained: got %b want 0", e_valid_o); else n_pass++;
    endtask

    task automatic test_packet_lock();
        logic [8:0] exp_o[4];
        int         saw;
        int         viol;
        bit         to;
        exp_o = '{9'h021, 9'h022, 9'h123, 9'h10A};
        saw = 0; viol = 0; to = 1'b1;
        @(negedge clk);
        clear_all();
        push_beat(2, 8'h21, 1'b0);
        push_beat(2, 8'h22, 1'b0);
        push_beat(2, 8'h23, 1'b1);
        push_beat(0, 8'h0A, 1'b1);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (grant_o[2]) begin
                saw++;
                if (i_ready_o[0]) viol++;
            end
            if (out_q.size() >= 4 && drained() && !busy_o && !e_valid_o) begin
                to = 1'b0;
                break;
            end
        end
        n_checks++; if (to !== 1'b0) $display("FAIL lock_timeout: got %b want 0", to); else n_pass++;
        n_checks++; if (saw != 3) $display("FAIL lock_grant_cycles: got %0d want 3", saw); else n_pass++;
        n_checks++; if (viol != 0) $display("FAIL lock_ready0: got %0d cycles want 0", viol); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= out_q.size()) $display("FAIL lock_out[%0d]: missing, want %h", i, exp_o[i]);
            else if (out_q[i] !== exp_o[i]) $display("FAIL lock_out[%0d]: got %h want %h", i, out_q[i], exp_o[i]);
            else n_pass++;
        end
        n_checks++;
        if (out_cyc.size() < 3) $display("FAIL lock_b2b: only %0d beats", out_cyc.size());
        else if (out_cyc[2] - out_cyc[0] != 2) $display("FAIL lock_b2b: got %0d want 2", out_cyc[2] - out_cyc[0]);
        else n_pass++;
        n_checks++;
        if (gnt_q.size() != 2) $display("FAIL lock_grants: got %0d grants want 2", gnt_q.size());
        else if ({gnt_q[0], gnt_q[1]} !== 8'b0100_0001) $display("FAIL lock_grants: got %b want 01000001", {gnt_q[0], gnt_q[1]});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [8:0] exp_o[6];
        bit         to;
        exp_o = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h136};
        @(negedge clk);
        clear_all();
        for (int i = 1; i <= 6; i++) push_beat(3, 8'(8'h30 + i), (i == 6));
        repeat (4) @(negedge clk);
        e_ready_i = 1'b0;
        @(negedge clk);
        n_checks++; if (i_ready_o !== 4'b0000) $display("FAIL bp_ready_full: got %b want 0000", i_ready_o); else n_pass++;
        n_checks++; if ({e_valid_o, e_data_o} !== 9'h132) $display("FAIL bp_main_hold: got %h want 132", {e_valid_o, e_data_o}); else n_pass++;
        n_checks++; if (grant_o !== 4'b1000) $display("FAIL bp_grant: got %b want 1000", grant_o); else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++; if (i_ready_o !== 4'b0000) $display("FAIL bp_ready_late: got %b want 0000", i_ready_o); else n_pass++;
        n_checks++; if ({e_valid_o, e_data_o} !== 9'h132) $display("FAIL bp_main_late: got %h want 132", {e_valid_o, e_data_o}); else n_pass++;
        e_ready_i = 1'b1;
        wait_done(6, to);
        n_checks++; if (to !== 1'b0) $display("FAIL bp_timeout: got %b want 0", to); else n_pass++;
        n_checks++; if (out_q.size() != 6) $display("FAIL bp_count: got %0d want 6", out_q.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= out_q.size()) $display("FAIL bp_out[%0d]: missing, want %h", i, exp_o[i]);
            else if (out_q[i] !== exp_o[i]) $display("FAIL bp_out[%0d]: got %h want %h", i, out_q[i], exp_o[i]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        bit to;
        @(negedge clk);
        clear_all();
        push_beat(2, 8'h2C, 1'b1);
        wait_done(1, to);
        n_checks++; if (to !== 1'b0) $display("FAIL wrap_setup_timeout: got %b want 0", to); else n_pass++;
        clear_all();
        push_beat(1, 8'h1B, 1'b1);
        push_beat(3, 8'h3B, 1'b1);
        wait_done(2, to);
        n_checks++; if (to !== 1'b0) $display("FAIL wrap_timeout: got %b want 0", to); else n_pass++;
        n_checks++;
        if (gnt_q.size() != 2) $display("FAIL wrap_grants: got %0d grants want 2", gnt_q.size());
        else if ({gnt_q[0], gnt_q[1]} !== 8'b1000_0010) $display("FAIL wrap_grants: got %b want 10000010", {gnt_q[0], gnt_q[1]});
        else n_pass++;
        n_checks++;
        if (out_q.size() != 2) $display("FAIL wrap_out: got %0d beats want 2", out_q.size());
        else if ({out_q[0], out_q[1]} !== {9'h13B, 9'h11B}) $display("FAIL wrap_out: got %h %h want 13b 11b", out_q[0], out_q[1]);
        else n_pass++;
        // The pointer now sits at 2, so req2 must beat req0.
        clear_all();
        push_beat(0, 8'h0D, 1'b1);
        push_beat(2, 8'h2D, 1'b1);
        wait_done(2, to);
        n_checks++; if (to !== 1'b0) $display("FAIL wrap_ptr_timeout: got %b want 0", to); else n_pass++;
        n_checks++;
        if (gnt_q.size() != 2) $display("FAIL wrap_ptr2: got %0d grants want 2", gnt_q.size());
        else if ({gnt_q[0], gnt_q[1]} !== 8'b0100_0001) $display("FAIL wrap_ptr2: got %b want 01000001", {gnt_q[0], gnt_q[1]});
        else n_pass++;
    endtask

    task automatic test_valid_gap();
        logic [8:0] exp_o[4];
        bit         to;
        exp_o = '{9'h011, 9'h012, 9'h113, 9'h10E};
        @(negedge clk);
        clear_all();
        push_beat(1, 8'h11, 1'b0);
        push_beat(1, 8'h12, 1'b0);
        push_beat(1, 8'h13, 1'b1);
        push_beat(0, 8'h0E, 1'b1);
        repeat (2) @(negedge clk);
        hold[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if ({busy_o, grant_o} !== 5'b10010) $display("FAIL gap_hold[%0d]: got %b want 10010", c, {busy_o, grant_o}); else n_pass++;
        end
        hold[1] = 1'b0;
        wait_done(4, to);
        n_checks++; if (to !== 1'b0) $display("FAIL gap_timeout: got %b want 0", to); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= out_q.size()) $display("FAIL gap_out[%0d]: missing, want %h", i, exp_o[i]);
            else if (out_q[i] !== exp_o[i]) $display("FAIL gap_out[%0d]: got %h want %h", i, out_q[i], exp_o[i]);
            else n_pass++;
        end
        n_checks++;
        if (gnt_q.size() != 2) $display("FAIL gap_grants: got %0d grants want 2", gnt_q.size());
        else if ({gnt_q[0], gnt_q[1]} !== 8'b0010_0001) $display("FAIL gap_grants: got %b want 00100001", {gnt_q[0], gnt_q[1]});
        else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        @(negedge clk);
        clear_all();
        e_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) push_beat(0, 8'(8'h40 + i), (i == 4));
        repeat (4) @(negedge clk);
        n_checks++; if ({busy_o, e_valid_o} !== 2'b11) $display("FAIL mid_pre: got %b want 11", {busy_o, e_valid_o}); else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (e_valid_o !== 1'b0) $display("FAIL mid_e_valid: got %b want 0", e_valid_o); else n_pass++;
        n_checks++; if (grant_o !== 4'b0000) $display("FAIL mid_grant: got %b want 0000", grant_o); else n_pass++;
        n_checks++; if (i_ready_o !== 4'b0000) $display("FAIL mid_i_ready: got %b want 0000", i_ready_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy_o); else n_pass++;
        clear_all();
        repeat (2) @(negedge clk);
        e_ready_i = 1'b1;
        reset_n   = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if ({busy_o, e_valid_o} !== 2'b00) $display("FAIL mid_after: got %b want 00", {busy_o, e_valid_o}); else n_pass++;
        n_checks++; if (out_q.size() != 0) $display("FAIL mid_discard: got %0d beats want 0", out_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_latency();
        test_packet_lock();
        test_backpressure();
        test_wrap();
        test_valid_gap();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_stream_arbiter.md
RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 1..8.
REQ-002 SHALL have parameter DATA_W, default 8: beat data width.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock domain only.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_valid_i  input  NUM_REQ  per-requester beat valid.
REQ-006 SHALL have port i_data_i  input  NUM_REQ*DATA_W  requester k's data at bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port i_last_i  input  NUM_REQ  per-requester end-of-packet marker.
REQ-008 SHALL have port i_ready_o  output  NUM_REQ  per-requester ready.
REQ-009 SHALL have port e_valid_o  output  1  egress valid.
REQ-010 SHALL have port e_data_o  output  DATA_W  egress data.
REQ-011 SHALL have port e_last_o  output  1  egress end-of-packet.
REQ-012 SHALL have port e_ready_i  input  1  egress ready.
REQ-013 SHALL have port grant_o  output  NUM_REQ  one-hot current grant, zero when no grant.
REQ-014 SHALL have port busy_o  output  1  high while in LOCKED.

Function
REQ-015 SHALL implement FSM states IDLE and LOCKED, plus a round-robin pointer ptr of width clog2(NUM_REQ), minimum 1 bit.
REQ-016 In IDLE, when any i_valid_i bit is set, SHALL grant the first valid requester scanning ptr, ptr+1, ... modulo NUM_REQ, register it into grant_o and move to LOCKED on the next edge.
REQ-017 SHALL drive grant_o = 0 and i_ready_o = 0 in IDLE; no beat is accepted in an arbitration cycle.
REQ-018 In LOCKED with grant g, SHALL drive i_ready_o[g] = !skid_valid and all other i_ready_o bits to 0.
REQ-019 A beat SHALL be accepted when i_valid_i[g] && i_ready_o[g]; data and last are captured together.
REQ-020 On an accepted beat with i_last_i[g] = 1, SHALL go to IDLE, clear grant_o and set ptr = (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-021 SHALL hold the grant while the granted requester drops valid mid-packet; no timeout, no preemption.
REQ-022 Egress stage SHALL be a two-entry buffer (main, skid); e_valid_o/e_data_o/e_last_o come directly from main.
REQ-023 An accepted beat SHALL go to main when main is empty or popped in the same cycle with skid empty; otherwise it goes to skid.
REQ-024 On a pop (e_valid_o && e_ready_i) with skid valid, SHALL move skid to main in the same edge.
REQ-025 Latency SHALL be 1 cycle from acceptance to e_valid_o with an empty buffer; order SHALL be preserved with no drop or duplication.
REQ-026 Throughput SHALL be 1 beat/cycle within a packet when e_ready_i = 1; single-beat packets SHALL achieve 1 beat per 2 cycles.
REQ-027 When NUM_REQ = 1, SHALL still take the IDLE arbitration cycle per packet, with ptr held at 0.

Reset
REQ-028 On reset_n = 0, SHALL asynchronously set state = IDLE, ptr = 0, main/skid valid = 0 and data/last regs = 0, which makes all outputs 0.
REQ-029 SHALL perform the first arbitration no earlier than the first rising clk edge with reset_n = 1; a partially transferred packet is discarded.

Verification
REQ-030 Reset mid-packet: reset_n low between edges while LOCKED with main full -> e_valid_o, grant_o, i_ready_o and busy_o are 0 immediately, with no clock edge.
REQ-031 Round-robin: all four valid, single-beat packets with data 0x0k, e_ready_i = 1 -> grants 0,1,2,3,0; e_data_o sequence 0x00,0x01,0x02,0x03,0x00.
REQ-032 Packet lock: req2 sends 0x21,0x22,0x23 (last) while req0 stays valid -> output 0x21,0x22,0x23 before req0's beat; i_ready_o[0] = 0 throughout.
REQ-033 Backpressure: e_ready_i = 0 for 5 cycles mid-packet -> main and skid hold 2 beats and i_ready_o[g] = 0; after release, beats emerge in order with no loss.
REQ-034 Wrap: ptr = 3, only req1 and req3 valid -> req3 granted first, then req1, then ptr = 2.
REQ-035 Valid gap: granted req1 drops valid for 3 cycles mid-packet while req0 is valid -> grant_o stays 4'b0010; req1's packet completes before req0 is granted.
